scan_mux: RTL and testbench
===========================

SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter WIDTH, default 8: bits per channel, legal range 1..32.
REQ-003 Parameter DWELL, default 3: clock cycles spent on each channel in scan mode, legal range 1..65535.
REQ-004 Derived SELW = max(1, ceil(log2(CHANNELS))); not user-settable.
REQ-005 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 din  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SELW  channel select used in manual mode.
REQ-009 auto_scan  input  1  0 = manual select, 1 = automatic round-robin scan.
REQ-010 hold  input  1  1 = freeze all state and outputs.
REQ-011 dout  output  WIDTH  registered data of the current channel.
REQ-012 cur_ch  output  SELW  registered index of the current channel.
REQ-013 ch_strobe  output  1  one-cycle pulse marking a change of cur_ch.

Function
REQ-014 The FSM SHALL have three states: MANUAL, SCAN, HOLD.
REQ-015 Transitions evaluated each edge: hold=1 -> HOLD (highest priority); else auto_scan=1 -> SCAN; else -> MANUAL.
REQ-016 In HOLD, cur_ch, dout, the dwell counter and ch_strobe SHALL retain their values (ch_strobe forced 0), regardless of din or sel.
REQ-017 In MANUAL, next cur_ch SHALL be sel when sel < CHANNELS; an out-of-range sel SHALL leave cur_ch unchanged.
REQ-018 In MANUAL, the dwell counter SHALL be held at 0.
REQ-019 In SCAN, the dwell counter SHALL increment each cycle; when it equals DWELL-1 it SHALL return to 0 and cur_ch SHALL advance by one.
REQ-020 Channel advance SHALL wrap from CHANNELS-1 to 0 (non-power-of-two CHANNELS included).
REQ-021 On entry to SCAN from MANUAL, the dwell counter SHALL start at 0 and scanning SHALL begin from the current cur_ch.
REQ-022 On leaving HOLD, the dwell counter SHALL resume from its frozen value (no restart).
REQ-023 With DWELL=1, cur_ch SHALL advance every cycle in SCAN.
REQ-024 In every non-HOLD cycle, dout SHALL load din slice indexed by the next value of cur_ch, so dout and cur_ch always describe the same channel; latency din -> dout is one cycle.
REQ-025 ch_strobe SHALL be 1 in exactly the cycle following any edge on which cur_ch changed value, else 0; re-selecting the same channel SHALL NOT pulse.
REQ-026 Simultaneous mode switch and dwell expiry: the new state's rule applies (manual sel wins when entering MANUAL).

Reset
REQ-027 While resetn=0, the block SHALL asynchronously force state=MANUAL, cur_ch=0, dout=0, dwell counter=0, ch_strobe=0.
REQ-028 Reset asserted mid-scan SHALL take effect without waiting for a clock edge; after release, the first edge follows MANUAL/SCAN/HOLD rules from the reset values.

Verification (CHANNELS=4, WIDTH=8, DWELL=3; din = {8'h44,8'h33,8'h22,8'h11})
REQ-029 Reset: resetn=0 asynchronously mid-cycle -> dout=8'h00, cur_ch=0, ch_strobe=0 immediately.
REQ-030 Manual: auto_scan=0, sel=2 -> one edge later cur_ch=2, dout=8'h33, ch_strobe=1 for one cycle; sel=2 held -> no further pulse.
REQ-031 Scan/wrap: from cur_ch=2, auto_scan=1 -> cur_ch sequence 2,2,2,3,3,3,0,0,0,1 with ch_strobe pulses on each change; dout tracks 33,44,11,22.
REQ-032 Hold: hold=1 during scan with din changed to all 8'hFF -> dout, cur_ch frozen, no strobe; hold=0 -> dwell count resumes, remaining dwell cycles honoured.
REQ-033 Out-of-range: CHANNELS=3 build, sel=3 in manual -> cur_ch unchanged; scan wraps 2 -> 0.
REQ-034 Async reset during SCAN with dwell counter=1 -> all outputs zero at once; after release with auto_scan=1, first advance occurs on the 3rd edge.

Source files
------------

// File: rtl/scan_mux.sv
// Channel scanner: selects one of CHANNELS input slices either manually or by
// timed round-robin scan, with a freeze input and a change-of-channel strobe.
module scan_mux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int DWELL    = 3,
    localparam int SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SELW-1:0]           sel,
    input  logic                      auto_scan,
    input  logic                      hold,
    output logic [WIDTH-1:0]          dout,
    output logic [SELW-1:0]           cur_ch,
    output logic                      ch_strobe
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [1:0] ST_MANUAL = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST    = SELW'(CHANNELS - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    dwell_cnt;
    logic [CW-1:0]    dwell_base;
    logic [CW-1:0]    dwell_nxt;
    logic [SELW-1:0]  ch_nxt;
    logic [WIDTH-1:0] ch_data [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slice
        assign ch_data[k] = din[k*WIDTH +: WIDTH];
    end

    always_comb begin
        if (hold)
            state_nxt = ST_HOLD;
        else if (auto_scan)
            state_nxt = ST_SCAN;
        else
            state_nxt = ST_MANUAL;
    end

    // The rule of the state being entered governs this edge, so a mode change
    // and a dwell expiry on the same edge resolve in favour of the new mode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        ch_nxt     = cur_ch;
        dwell_nxt  = dwell_cnt;
        dwell_base = (state == ST_MANUAL) ? '0 : dwell_cnt;
        case (state_nxt)
            ST_SCAN: begin
                if (dwell_base == DWELL_LAST) begin
                    dwell_nxt = '0;
                    ch_nxt    = (cur_ch == CH_LAST) ? '0 : cur_ch + SELW'(1);
                end else begin
                    dwell_nxt = dwell_base + CW'(1);
                end
            end
            ST_MANUAL: begin
                dwell_nxt = '0;
                if (32'(sel) < CHANNELS)
                    ch_nxt = sel;
            end
            default: ;
        endcase
    end

    // dout is loaded from the slice that cur_ch is about to point at, so the
    // two outputs always describe the same channel.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!resetn) begin
            state     <= ST_MANUAL;
            cur_ch    <= '0;
            dout      <= '0;
            dwell_cnt <= '0;
            ch_strobe <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != ST_HOLD) begin
                cur_ch    <= ch_nxt;
                dwell_cnt <= dwell_nxt;
                dout      <= ch_data[ch_nxt];
                ch_strobe <= (ch_nxt != cur_ch);
            end else begin
                ch_strobe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: a 4-channel and a 3-channel instance driven by
// directed vectors; expectations are queued and checked by a separate monitor.
module tb_scan_mux;

    typedef struct {
        int         dut;
        string      name;
        logic [1:0] cur;
        logic [7:0] dout;
        logic       strobe;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  sel;
    logic        auto_scan;
    logic        hold;
    logic [31:0] din_a;
    logic [23:0] din_b;
    logic [7:0]  dout_a, dout_b;
    logic [1:0]  cur_a, cur_b;
    logic        str_a, str_b;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    event async_ev;

    always #5 clk = ~clk;

    scan_mux #(.CHANNELS(4), .WIDTH(8), .DWELL(3)) dut_a (
        .CLOCK_50(clk), .resetn(resetn), .din(din_a), .sel(sel),
        .auto_scan(auto_scan), .hold(hold),
        .dout(dout_a), .cur_ch(cur_a), .ch_strobe(str_a)
    );

    scan_mux #(.CHANNELS(3), .WIDTH(8), .DWELL(3)) dut_b (
        .CLOCK_50(clk), .resetn(resetn), .din(din_b), .sel(sel),
        .auto_scan(auto_scan), .hold(hold),
        .dout(dout_b), .cur_ch(cur_b), .ch_strobe(str_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a falling edge: drive inputs, queue the expectation for the
    // next rising edge, then return at the following falling edge.
    task automatic step(input int dut, input string name, input logic [1:0] s,
                        input logic a, input logic h,
                        input logic [1:0] ec, input logic [7:0] ed, input logic es);
        exp_t e;
        sel = s; auto_scan = a; hold = h;
        e.dut = dut; e.name = name; e.cur = ec; e.dout = ed; e.strobe = es;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Reset asserted between edges; the monitor samples before the next edge.
    task automatic async_reset(input string name);
        exp_t e;
        resetn = 1'b0;
        e.dut = 0; e.name = name; e.cur = 2'd0; e.dout = 8'h00; e.strobe = 1'b0;
        sb.push_back(e);
        ->async_ev;
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or async_ev);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.dut == 0) begin
                    check({e.name, ".cur_ch"},    32'(cur_a),  32'(e.cur));
                    check({e.name, ".dout"},      32'(dout_a), 32'(e.dout));
                    check({e.name, ".ch_strobe"}, 32'(str_a),  32'(e.strobe));
                end else begin
                    check({e.name, ".cur_ch"},    32'(cur_b),  32'(e.cur));
                    check({e.name, ".dout"},      32'(dout_b), 32'(e.dout));
                    check({e.name, ".ch_strobe"}, 32'(str_b),  32'(e.strobe));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        resetn = 1'b0; sel = 2'd0; auto_scan = 1'b0; hold = 1'b0;
        din_a = {8'h44, 8'h33, 8'h22, 8'h11};
        din_b = {8'hCC, 8'hBB, 8'hAA};
        @(negedge clk);
        step(0, "reset_held", 2'd0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        resetn = 1'b1;

        // Manual selection
        step(0, "man_sel0",   2'd0, 1'b0, 1'b0, 2'd0, 8'h11, 1'b0);
        step(0, "man_sel2",   2'd2, 1'b0, 1'b0, 2'd2, 8'h33, 1'b1);
        step(0, "man_same",   2'd2, 1'b0, 1'b0, 2'd2, 8'h33, 1'b0);

        // Scan from channel 2, wrap 3 -> 0
        step(0, "scan_e1",    2'd2, 1'b1, 1'b0, 2'd2, 8'h33, 1'b0);
        step(0, "scan_e2",    2'd2, 1'b1, 1'b0, 2'd2, 8'h33, 1'b0);
        step(0, "scan_e3",    2'd2, 1'b1, 1'b0, 2'd3, 8'h44, 1'b1);
        step(0, "scan_e4",    2'd2, 1'b1, 1'b0, 2'd3, 8'h44, 1'b0);
        step(0, "scan_e5",    2'd2, 1'b1, 1'b0, 2'd3, 8'h44, 1'b0);
        step(0, "scan_wrap",  2'd2, 1'b1, 1'b0, 2'd0, 8'h11, 1'b1);
        step(0, "scan_e7",    2'd2, 1'b1, 1'b0, 2'd0, 8'h11, 1'b0);

        // Hold with dwell counter at 1, din changed
        din_a = 32'hFFFF_FFFF;
        step(0, "hold_1",     2'd1, 1'b1, 1'b1, 2'd0, 8'h11, 1'b0);
        step(0, "hold_2",     2'd3, 1'b0, 1'b1, 2'd0, 8'h11, 1'b0);
        din_a = {8'h44, 8'h33, 8'h22, 8'h11};
        step(0, "resume_1",   2'd2, 1'b1, 1'b0, 2'd0, 8'h11, 1'b0);
        step(0, "resume_adv", 2'd2, 1'b1, 1'b0, 2'd1, 8'h22, 1'b1);

        // Switch to manual on the dwell-expiry edge: sel wins over scan advance
        step(0, "pre_sw_1",   2'd3, 1'b1, 1'b0, 2'd1, 8'h22, 1'b0);
        step(0, "pre_sw_2",   2'd3, 1'b1, 1'b0, 2'd1, 8'h22, 1'b0);
        step(0, "switch_man", 2'd3, 1'b0, 1'b0, 2'd3, 8'h44, 1'b1);
        step(0, "man_hold3",  2'd3, 1'b0, 1'b0, 2'd3, 8'h44, 1'b0);

        // Async reset mid-scan with dwell counter at 1
        step(0, "scan_d1",    2'd3, 1'b1, 1'b0, 2'd3, 8'h44, 1'b0);
        async_reset("async_rst");
        resetn = 1'b1;
        step(0, "post_rst_1", 2'd0, 1'b1, 1'b0, 2'd0, 8'h11, 1'b0);
        step(0, "post_rst_2", 2'd0, 1'b1, 1'b0, 2'd0, 8'h11, 1'b0);
        step(0, "post_rst_3", 2'd0, 1'b1, 1'b0, 2'd1, 8'h22, 1'b1);

        // Three-channel instance: out-of-range sel and 2 -> 0 wrap
        resetn = 1'b0; auto_scan = 1'b0; sel = 2'd0;
        @(negedge clk);
        resetn = 1'b1;
        step(1, "b_sel2",     2'd2, 1'b0, 1'b0, 2'd2, 8'hCC, 1'b1);
        step(1, "b_sel_oor",  2'd3, 1'b0, 1'b0, 2'd2, 8'hCC, 1'b0);
        step(1, "b_scan_e1",  2'd3, 1'b1, 1'b0, 2'd2, 8'hCC, 1'b0);
        step(1, "b_scan_e2",  2'd3, 1'b1, 1'b0, 2'd2, 8'hCC, 1'b0);
        step(1, "b_wrap",     2'd3, 1'b1, 1'b0, 2'd0, 8'hAA, 1'b1);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
